sha512_msg_padder: RTL

Stream-to-block front end for the HMAC-SHA-512 path. Accepts the 32-bit message stream (`msg_word`/`msg_valid`/`msg_last`/`msg_ready`) and packs it big-endian into 1024-bit SHA-512 blocks. It applies FIPS 180-4 padding (0x80 marker, zero fill, 128-bit bit-length) and hands blocks to the SHA-512 compression core over a valid/ready port. The length field includes a fixed prefix offset, so the inner-hash ipad block is counted.

---
 rtl/sha512_pkg.sv | 29 ++
 rtl/sha512_msg_padder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sha512_pkg.sv
// Shared SHA-512 constants, the padder state type and a length-block helper.
package sha512_pkg;

    localparam int unsigned SHA512_BLOCK_W       = 1024;
    localparam int unsigned SHA512_WORD_W        = 32;
    localparam int unsigned SHA512_WORDS_PER_BLK = 32;
    localparam int unsigned SHA512_LEN_W         = 128;
    localparam logic [31:0] SHA512_PAD_WORD      = 32'h8000_0000;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } sha512_pad_state_e;

    // Trailing block holding only the length (and optionally the 0x80 marker in slot 0).
    function automatic logic [SHA512_BLOCK_W-1:0] sha512_len_block(
        input logic [63:0] len,
        input logic        pad_first
    );
        logic [SHA512_BLOCK_W-1:0] b;
        b = '0;
        if (pad_first) begin
            b[SHA512_BLOCK_W-1 -: SHA512_WORD_W] = SHA512_PAD_WORD;
        end
        b[SHA512_LEN_W-1:0] = {64'd0, len};
        return b;
    endfunction

endpackage

// File: rtl/sha512_msg_padder.sv
// Packs a 32-bit word stream big-endian into 1024-bit SHA-512 blocks and
// appends FIPS 180-4 padding with a length field offset by LEN_OFFSET bits.
module sha512_msg_padder
    import sha512_pkg::*;
#(
    parameter logic [63:0] LEN_OFFSET = 64'd1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SHA512_WORD_W-1:0]  msg_word,
    input  logic                      msg_valid,
    input  logic                      msg_last,
    output logic                      msg_ready,
    output logic [SHA512_BLOCK_W-1:0] blk_data,
    output logic                      blk_valid,
    output logic                      blk_last,
    input  logic                      blk_ready,
    output logic                      busy
);

    sha512_pad_state_e         state_q, state_d;
    logic [4:0]                wcnt_q, wcnt_d;
    logic [63:0]               len_q, len_d, len_inc;
    logic [1:0]                extra_q, extra_d;
    logic [SHA512_BLOCK_W-1:0] blk_q, blk_d, fill_blk;
    logic                      blk_last_q, blk_last_d;
    logic                      busy_q, busy_d;
    logic [SHA512_WORD_W-1:0]  buf_q [SHA512_WORDS_PER_BLK];
    logic [5:0]                nslot;
    logic                      word_acc;
    logic [SHA512_WORD_W-1:0]  slot_w;

    assign msg_ready = reset && (state_q == S_FILL);
    assign blk_valid = (state_q == S_EMIT);
    assign blk_data  = blk_q;
    assign blk_last  = blk_last_q;
    assign busy      = busy_q;

    assign word_acc  = msg_valid && msg_ready;
    assign nslot     = {1'b0, wcnt_q} + 6'd1;
    assign len_inc   = len_q + 64'd32;

    // Compose the outgoing block from buffered words, the incoming word and padding.
    always_comb begin
        fill_blk = '0;
        slot_w   = '0;
        for (int unsigned i = 0; i < SHA512_WORDS_PER_BLK; i++) begin
            slot_w = '0;
            if (i < 32'(wcnt_q)) begin
                slot_w = buf_q[i];
            end else if (i == 32'(wcnt_q)) begin
                slot_w = msg_word;
            end else if (msg_last && (i == 32'(nslot))) begin
                slot_w = SHA512_PAD_WORD;
            end
            fill_blk[SHA512_BLOCK_W-1-SHA512_WORD_W*i -: SHA512_WORD_W] = slot_w;
        end
        if (msg_last && (nslot <= 6'd27)) begin
            fill_blk[SHA512_LEN_W-1:0] = {64'd0, len_inc};
        end
    end

    // Next-state logic for fill/emit sequencing and trailing-block generation.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        len_d      = len_q;
        extra_d    = extra_q;
        blk_d      = blk_q;
        blk_last_d = blk_last_q;
        busy_d     = busy_q;
        case (state_q)
            S_FILL: begin
                if (word_acc) begin
                    busy_d = 1'b1;
                    len_d  = len_inc;
                    wcnt_d = wcnt_q + 5'd1;
                    if (msg_last) begin
                        state_d = S_EMIT;
                        wcnt_d  = '0;
                        blk_d   = fill_blk;
                        if (nslot <= 6'd27) begin
                            blk_last_d = 1'b1;
                            extra_d    = 2'd0;
                        end else if (nslot <= 6'd31) begin
                            blk_last_d = 1'b0;
                            extra_d    = 2'd1;
                        end else begin
                            blk_last_d = 1'b0;
                            extra_d    = 2'd2;
                        end
                    end else if (wcnt_q == 5'd31) begin
                        state_d    = S_EMIT;
                        wcnt_d     = '0;
                        blk_d      = fill_blk;
                        blk_last_d = 1'b0;
                        extra_d    = 2'd0;
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    if (extra_q != 2'd0) begin
                        blk_d      = sha512_len_block(len_q, extra_q == 2'd2);
                        blk_last_d = 1'b1;
                        extra_d    = 2'd0;
                    end else begin
                        state_d = S_FILL;
                        if (blk_last_q) begin
                            len_d      = LEN_OFFSET;
                            wcnt_d     = '0;
                            busy_d     = 1'b0;
                            blk_last_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FILL;
            wcnt_q     <= '0;
            len_q      <= LEN_OFFSET;
            extra_q    <= '0;
            blk_q      <= '0;
            blk_last_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            extra_q    <= extra_d;
            blk_q      <= blk_d;
            blk_last_q <= blk_last_d;
            busy_q     <= busy_d;
        end
    end

    // Word buffer: each accepted word lands in its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SHA512_WORDS_PER_BLK; i++) begin
                buf_q[i] <= '0;
            end
        end else if (word_acc) begin
            buf_q[wcnt_q] <= msg_word;
        end
    end

endmodule
